// File: rtl/src_ctrl.sv
// src_ctrl: source-side stream controller; writes a DEPTH-word frame into the local buffer,
// pulses s_fin_out to start the core, then holds the source off until comp_done. Option: SRC_LAST_EN.
module src_ctrl #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          src_valid,
   input  logic          src_last,
   input  logic          comp_done,
   output logic          src_ready,
   output logic          stream_v,
   output logic [AW-1:0] stream_a,
   output logic          s_fin_out,
   output logic [AW:0]   s_len
);

   typedef enum logic [1:0] {IDLE, RECV, WAIT} state_t;

   localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

   state_t      state;
   state_t      state_next;
   logic [AW:0] cnt;
   logic        fin_q;
   logic        accept;
   logic        final_accept;
   logic        clear;

   assign clear  = rst | ~run;
   assign accept = src_valid & (state == RECV);

`ifdef SRC_LAST_EN
   assign final_accept = accept & ((cnt == LAST_ADDR) | src_last);
`else
   logic unused_src_last;
   assign unused_src_last = src_last;
   assign final_accept    = accept & (cnt == LAST_ADDR);
`endif

   always_ff @(posedge clk) begin
      if (clear)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = RECV;
         RECV:    if (final_accept) state_next = WAIT;
         WAIT:    if (comp_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // fin_q is set by the final accept, so it is high for exactly the first WAIT cycle
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt   <= '0;
         s_len <= '0;
         fin_q <= 1'b0;
      end else begin
         fin_q <= final_accept;
         case (state)
            IDLE: cnt <= '0;
            RECV: begin
               if (accept)
                  cnt <= cnt + 1'b1;
               if (final_accept)
                  s_len <= cnt + 1'b1;
            end
            WAIT: if (comp_done) cnt <= '0;
            default: cnt <= '0;
         endcase
      end
   end

   always_comb begin
      src_ready = (state == RECV);
      stream_v  = accept;
      stream_a  = cnt[AW-1:0];
      s_fin_out = fin_q;
   end

endmodule

// File: tb/tb_src_ctrl.sv
// tb_src_ctrl: directed frame scenarios plus randomized traffic, checked every cycle
// against a frame-level reference model of src_ctrl.
module tb_src_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          src_valid;
   logic          src_last;
   logic          comp_done;
   logic          src_ready;
   logic          stream_v;
   logic [AW-1:0] stream_a;
   logic          s_fin_out;
   logic [AW:0]   s_len;

   int vectors    = 0;
   int miscompares = 0;

   src_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .src_valid (src_valid),
      .src_last  (src_last),
      .comp_done (comp_done),
      .src_ready (src_ready),
      .stream_v  (stream_v),
      .stream_a  (stream_a),
      .s_fin_out (s_fin_out),
      .s_len     (s_len)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 = idle, 1 = receiving, 2 = waiting on the core
   int m_phase;
   int m_words;
   int m_len;
   bit m_first_wait;
   bit model_live = 1'b0;

   always @(posedge clk) begin
      model_live <= 1'b1;
      if (rst || !run) begin
         m_phase      <= 0;
         m_words      <= 0;
         m_len        <= 0;
         m_first_wait <= 1'b0;
      end else if (m_phase == 0) begin
         m_phase      <= 1;
         m_words      <= 0;
         m_first_wait <= 1'b0;
      end else if (m_phase == 1) begin
         m_first_wait <= 1'b0;
         if (src_valid) begin
            m_words <= m_words + 1;
`ifdef SRC_LAST_EN
            if (m_words + 1 == DEPTH || src_last) begin
`else
            if (m_words + 1 == DEPTH) begin
`endif
               m_phase      <= 2;
               m_len        <= m_words + 1;
               m_first_wait <= 1'b1;
            end
         end
      end else begin
         m_first_wait <= 1'b0;
         if (comp_done) begin
            m_phase <= 0;
            m_words <= 0;
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         checkOutput("src_ready", int'(src_ready), int'(m_phase == 1));
         checkOutput("stream_v", int'(stream_v), int'(m_phase == 1 && src_valid));
         checkOutput("stream_a", int'(stream_a), m_words % DEPTH);
         checkOutput("s_fin_out", int'(s_fin_out), int'(m_phase == 2 && m_first_wait));
         checkOutput("s_len", int'(s_len), m_len);
      end
   end

   task automatic applyStimulus(input logic r, input logic rn, input logic v, input logic l, input logic cd);
      rst       = r;
      run       = rn;
      src_valid = v;
      src_last  = l;
      comp_done = cd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1, 1, 0, 0, 0);
      tick();
      tick();
   endtask

   initial begin
      int fin1;
      int fin2;
      logic cd;

      applyStimulus(1, 0, 0, 0, 0);
      doReset();
      checkOutput("reset_ready", int'(src_ready), 0);
      checkOutput("reset_addr", int'(stream_a), 0);
      checkOutput("reset_fin", int'(s_fin_out), 0);
      checkOutput("reset_len", int'(s_len), 0);

      // Full frame with src_valid held high
      applyStimulus(0, 1, 1, 0, 0);
      tick();
      checkOutput("idle_to_recv_ready", int'(src_ready), 1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 1, 1, 0, 0);
         checkOutput("full_addr", int'(stream_a), i);
         checkOutput("full_strobe", int'(stream_v), 1);
         tick();
      end
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("full_fin", int'(s_fin_out), 1);
      checkOutput("full_len", int'(s_len), 8);
      checkOutput("full_ready_drop", int'(src_ready), 0);
      checkOutput("model_len_pin", m_len, 8);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("delayed_done_fin", int'(s_fin_out), 0);
         checkOutput("delayed_done_ready", int'(src_ready), 0);
      end
      applyStimulus(0, 1, 0, 0, 1);
      tick();
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("done_to_idle", int'(src_ready), 0);
      tick();
      checkOutput("idle_to_recv", int'(src_ready), 1);

      // Toggled src_valid: addresses still sequential
      for (int i = 0; i < 2 * DEPTH; i++) begin
         applyStimulus(0, 1, (i % 2) == 1, 0, 0);
         checkOutput("toggle_strobe", int'(stream_v), i % 2);
         if (i % 2 == 1)
            checkOutput("toggle_addr", int'(stream_a), i / 2);
         tick();
      end
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("toggle_fin", int'(s_fin_out), 1);
      tick();
      applyStimulus(0, 1, 0, 0, 1);
      checkOutput("held_done_idle", int'(src_ready), 0);
      tick();
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("held_done_recv", int'(src_ready), 1);

      // src_last on the third word
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, i == 2, 0);
         tick();
      end
      applyStimulus(0, 1, 0, 0, 0);
`ifdef SRC_LAST_EN
      checkOutput("short_fin", int'(s_fin_out), 1);
      checkOutput("short_len", int'(s_len), 3);
`else
      checkOutput("ignored_last_fin", int'(s_fin_out), 0);
      checkOutput("ignored_last_addr", int'(stream_a), 3);
      for (int i = 3; i < DEPTH; i++) begin
         applyStimulus(0, 1, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("ignored_last_fin_end", int'(s_fin_out), 1);
      checkOutput("ignored_last_len", int'(s_len), 8);
`endif
      applyStimulus(0, 1, 0, 0, 1);
      tick();
      applyStimulus(0, 1, 0, 0, 0);
      tick();

      // run dropped mid-frame after 5 accepts
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 1, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 1, 0, 0);
      tick();
      checkOutput("abort_addr", int'(stream_a), 0);
      checkOutput("abort_ready", int'(src_ready), 0);
      checkOutput("abort_fin", int'(s_fin_out), 0);
      checkOutput("abort_len", int'(s_len), 0);
      applyStimulus(0, 1, 1, 0, 0);
      tick();
      checkOutput("restart_ready", int'(src_ready), 1);
      checkOutput("restart_addr", int'(stream_a), 0);

      // Back-to-back frames, core answers the cycle after it sees s_fin_out
      doReset();
      fin1 = -1;
      fin2 = -1;
      cd   = 1'b0;
      for (int k = 0; k < 60 && fin2 < 0; k++) begin
         applyStimulus(0, 1, 1, 0, cd);
         if (s_fin_out) begin
            if (fin1 < 0) fin1 = k;
            else          fin2 = k;
         end
         cd = s_fin_out;
         tick();
      end
      checkOutput("b2b_second_seen", int'(fin2 >= 0), 1);
      checkOutput("b2b_gap", fin2 - fin1, 11);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom % 100) == 0, ($urandom % 50) != 0, ($urandom % 10) < 7,
                       ($urandom % 8) == 0, ($urandom % 3) == 0);
         tick();
      end

      applyStimulus(1, 0, 0, 0, 0);
      tick();
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
